// File: rtl/mem_byte_arbiter_if.sv
// rtl/mem_byte_arbiter_if.sv - core request ports and byte-wide RAM/IO bus of the byte arbiter
interface mem_byte_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              rdy_in;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              flush_i;
  logic [31:0]       if_inst_o;
  logic              if_done_o;
  logic              ls_req_i;
  logic              ls_we_i;
  logic [1:0]        ls_size_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [31:0]       ls_wdata_i;
  logic [31:0]       ls_rdata_o;
  logic              ls_done_o;
  logic              stall_o;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  rdy_in, if_req_i, if_addr_i, flush_i, ls_req_i, ls_we_i, ls_size_i,
           ls_addr_i, ls_wdata_i, mem_din,
    output if_inst_o, if_done_o, ls_rdata_o, ls_done_o, stall_o, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, if_req_i, if_addr_i, flush_i, ls_req_i, ls_we_i, ls_size_i,
           ls_addr_i, ls_wdata_i, mem_din,
    input  if_inst_o, if_done_o, ls_rdata_o, ls_done_o, stall_o, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_byte_arbiter.sv
// rtl/mem_byte_arbiter.sv - arbitrates fetch and load/store ports onto a byte-wide RAM/IO bus
module mem_byte_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input logic              clk_in,
  input logic              rst_in,
  mem_byte_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              own_ls;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [1:0]        last_q;
  logic [1:0]        iss_q;
  logic [1:0]        cap_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       ls_rdata_q;
  logic [7:0]        dout_q;
  logic              a_vld_q;
  logic              pend_q;
  logic              pend_io_q;
  logic              wr_q;
  logic              if_done_q;
  logic              ls_done_q;

  logic [1:0]        ls_last;
  logic [1:0]        iss_inc;
  logic              io_hold;
  logic              run;
  logic [31:0]       cap_word;
  logic [ADDR_W-1:0] next_a;
  logic [ADDR_W-1:0] rewind_a;
  logic [7:0]        next_byte;

  // Decode size, pause override and the next byte address/data/capture word
  always_comb begin
    ls_last   = (bus.ls_size_i == 2'd2) ? 2'd3 : bus.ls_size_i;
    // an I/O byte on the bus or in flight must complete, so a pause is ignored then
    io_hold   = (a_vld_q && (mem_a_q[17:16] == IO_SEL)) || (pend_q && pend_io_q);
    run       = bus.rdy_in || io_hold;
    iss_inc   = iss_q + 2'd1;
    cap_word  = buf_q;
    cap_word[{cap_q, 3'b000} +: 8] = bus.mem_din;
    next_a    = addr_q + ADDR_W'(iss_inc);
    rewind_a  = addr_q + ADDR_W'(cap_q);
    next_byte = wdata_q[{iss_inc, 3'b000} +: 8];
  end

  // Access sequencer: accept in IDLE, issue/capture bytes, pulse done, return to IDLE
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      own_ls     <= 1'b0;
      addr_q     <= '0;
      mem_a_q    <= '0;
      last_q     <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      if_inst_q  <= '0;
      ls_rdata_q <= '0;
      dout_q     <= '0;
      a_vld_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_io_q  <= 1'b0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rdy_in && (bus.ls_req_i || bus.if_req_i)) begin
            own_ls    <= bus.ls_req_i;
            addr_q    <= bus.ls_req_i ? bus.ls_addr_i : bus.if_addr_i;
            mem_a_q   <= bus.ls_req_i ? bus.ls_addr_i : bus.if_addr_i;
            last_q    <= bus.ls_req_i ? ls_last : 2'd3;
            wdata_q   <= bus.ls_wdata_i;
            buf_q     <= '0;
            iss_q     <= '0;
            cap_q     <= '0;
            pend_q    <= 1'b0;
            pend_io_q <= 1'b0;
            if (bus.ls_req_i && bus.ls_we_i) begin
              state   <= WRITE;
              dout_q  <= bus.ls_wdata_i[7:0];
              wr_q    <= 1'b1;
              a_vld_q <= 1'b0;
            end else begin
              state   <= READ;
              a_vld_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (bus.flush_i && !own_ls) begin
            state   <= IDLE;
            a_vld_q <= 1'b0;
            pend_q  <= 1'b0;
            mem_a_q <= '0;
          end else if (run) begin
            if (pend_q) begin
              buf_q <= cap_word;
              cap_q <= cap_q + 2'd1;
              if (cap_q == last_q) begin
                state <= DONE;
                if (own_ls) begin
                  ls_rdata_q <= cap_word;
                  ls_done_q  <= 1'b1;
                end else begin
                  if_inst_q <= cap_word;
                  if_done_q <= 1'b1;
                end
              end
            end
            pend_q    <= a_vld_q;
            pend_io_q <= (mem_a_q[17:16] == IO_SEL);
            if (a_vld_q && (iss_q != last_q)) begin
              iss_q   <= iss_inc;
              mem_a_q <= next_a;
            end else begin
              a_vld_q <= 1'b0;
              mem_a_q <= '0;
            end
          end else begin
            // pause: drop the byte in flight and re-present the first uncaptured one
            pend_q  <= 1'b0;
            a_vld_q <= 1'b1;
            iss_q   <= cap_q;
            mem_a_q <= rewind_a;
          end
        end
        WRITE: begin
          if (bus.rdy_in) begin
            if (iss_q == last_q) begin
              state     <= DONE;
              wr_q      <= 1'b0;
              mem_a_q   <= '0;
              dout_q    <= '0;
              ls_done_q <= 1'b1;
            end else begin
              iss_q   <= iss_inc;
              mem_a_q <= next_a;
              dout_q  <= next_byte;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_wr     = wr_q && bus.rdy_in;
  assign bus.if_inst_o  = if_inst_q;
  assign bus.if_done_o  = if_done_q;
  assign bus.ls_rdata_o = ls_rdata_q;
  assign bus.ls_done_o  = ls_done_q;
  assign bus.stall_o    = (state != IDLE) || bus.if_req_i || bus.ls_req_i;
endmodule

// File: tb/tb_mem_byte_arbiter.sv
// tb/tb_mem_byte_arbiter.sv - randomized and directed bench for mem_byte_arbiter against a byte-level model
module tb_mem_byte_arbiter;
  logic clk_in;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_byte_arbiter_if bus ();

  mem_byte_arbiter dut (
    .clk_in (clk_in),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] wlog    [$];
  logic [31:0] log_a   [0:63];
  logic        log_wr  [0:63];
  logic [7:0]  log_d   [0:63];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_get(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_get(a + k);
    return w;
  endfunction

  function automatic int io_bytes(input logic [31:0] a, input int n);
    logic [31:0] b;
    int c;
    c = 0;
    for (int k = 0; k < n; k++) begin
      b = a + k;
      if (b[17:16] == 2'b11) c++;
    end
    return c;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // byte-wide RAM: read data one cycle after the address, writes logged in order
  initial begin
    logic [31:0] a;
    bus.mem_din <= 8'h00;
    forever begin
      @(posedge clk_in);
      a = bus.mem_a;
      bus.mem_din <= ram_get(a);
      if (bus.mem_wr === 1'b1) begin
        ram[a] = bus.mem_dout;
        wlog.push_back({a, bus.mem_dout});
      end
    end
  end

  task automatic do_acc(input bit is_ls, input bit we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, input bit rnd_rdy,
                        input int p_start, input int p_len, input int flush_cyc,
                        input logic [31:0] new_addr, output int done_cyc,
                        output logic [31:0] data, output int io_rd);
    int c;
    for (int i = 0; i < 64; i++) begin
      log_a[i]  = 32'hDEADBEEF;
      log_wr[i] = 1'bx;
      log_d[i]  = 8'hxx;
    end
    @(negedge clk_in);
    if (is_ls) begin
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = we;
      bus.ls_size_i  = sz;
      bus.ls_addr_i  = addr;
      bus.ls_wdata_i = wd;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    bus.rdy_in = rnd_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
    done_cyc = -1;
    data     = '0;
    io_rd    = 0;
    c        = 0;
    while (c < 60 && done_cyc < 0) begin
      @(negedge clk_in);
      c++;
      bus.rdy_in  = rnd_rdy ? ($urandom_range(0, 4) != 0) : !(c >= p_start && c < p_start + p_len);
      bus.flush_i = (c == flush_cyc);
      if (c == flush_cyc) bus.if_addr_i = new_addr;
      #1;
      log_a[c]  = bus.mem_a;
      log_wr[c] = bus.mem_wr;
      log_d[c]  = bus.mem_dout;
      if (!(is_ls && we) && bus.mem_a[17:16] == 2'b11) io_rd++;
      if (is_ls ? bus.ls_done_o : bus.if_done_o) begin
        done_cyc = c;
        data     = is_ls ? bus.ls_rdata_o : bus.if_inst_o;
        bus.ls_req_i = 1'b0;
        bus.if_req_i = 1'b0;
      end
    end
    bus.ls_req_i = 1'b0;
    bus.if_req_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.rdy_in   = 1'b1;
    if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

  initial begin
    int          dc;
    int          io;
    int          n;
    int          ls_c;
    int          if_c;
    int          c;
    bit          seen;
    bit          is_ls;
    bit          we;
    logic [1:0]  sz;
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] a5;

    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus.rdy_in     = 1'b1;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.flush_i    = 1'b0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_size_i  = '0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    preload(32'h0, 8'h13);
    preload(32'h1, 8'h01);
    preload(32'h2, 8'h00);
    preload(32'h3, 8'h00);
    preload(32'h104, 8'hAB);

    repeat (2) @(negedge clk_in);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("rst_if_inst", bus.if_inst_o, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata_o, 32'h0);
    chk("rst_done", {30'd0, bus.if_done_o, bus.ls_done_o}, 32'd0);
    rst_n = 1'b1;

    // word fetch at 0
    do_acc(1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0, 0, 0, -1, 32'h0, dc, d, io);
    chk("t1_done_cyc", dc, 6);
    chk("t1_inst", d, 32'h00000113);
    for (int k = 1; k <= 4; k++) chk("t1_mem_a", log_a[k], k - 1);
    chk("t1_no_wr", {31'd0, log_wr[2]}, 32'd0);

    // simultaneous requests: load byte wins, fetch follows
    @(negedge clk_in);
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_size_i = 2'd0;
    bus.ls_addr_i = 32'h104;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0;
    ls_c = -1;
    if_c = -1;
    a5   = 32'hDEADBEEF;
    c    = 0;
    while (c < 40 && if_c < 0) begin
      @(negedge clk_in);
      c++;
      #1;
      if (c == 5) a5 = bus.mem_a;
      if (bus.ls_done_o) begin
        ls_c = c;
        chk("t2_ls_data", bus.ls_rdata_o, 32'h000000AB);
        bus.ls_req_i = 1'b0;
      end
      if (bus.if_done_o) begin
        if_c = c;
        chk("t2_if_data", bus.if_inst_o, 32'h00000113);
        bus.if_req_i = 1'b0;
      end
    end
    bus.ls_req_i = 1'b0;
    bus.if_req_i = 1'b0;
    chk("t2_ls_cyc", ls_c, 3);
    chk("t2_if_cyc", if_c, 10);
    chk("t2_if_a5", a5, 32'h0);
    chk("t2_ls_hold", bus.ls_rdata_o, 32'h000000AB);

    // store half
    wlog.delete();
    do_acc(1'b1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF, 1'b0, 0, 0, -1, 32'h0, dc, d, io);
    ref_mem[32'h200] = 8'hEF;
    ref_mem[32'h201] = 8'hBE;
    chk("t3_a1", log_a[1], 32'h200);
    chk("t3_d1", {24'd0, log_d[1]}, 32'hEF);
    chk("t3_w1", {31'd0, log_wr[1]}, 32'd1);
    chk("t3_a2", log_a[2], 32'h201);
    chk("t3_d2", {24'd0, log_d[2]}, 32'hBE);
    chk("t3_w2", {31'd0, log_wr[2]}, 32'd1);
    chk("t3_done_cyc", dc, 3);
    chk("t3_w3", {31'd0, log_wr[3]}, 32'd0);
    chk("t3_wcount", wlog.size(), 2);

    // pause for 3 cycles while byte 2 is in flight
    do_acc(1'b0, 1'b0, 2'd3, 32'h1000, 32'h0, 1'b0, 4, 3, -1, 32'h0, dc, d, io);
    chk("t4_done_cyc", dc, 10);
    chk("t4_data", d, ref_word(32'h1000, 4));
    chk("t4_a3", log_a[3], 32'h1002);
    chk("t4_a7", log_a[7], 32'h1002);
    chk("t4_no_wr", {29'd0, log_wr[4], log_wr[5], log_wr[6]}, 32'd0);

    // flush in cycle 3, new fetch at 0x40
    do_acc(1'b0, 1'b0, 2'd3, 32'h80, 32'h0, 1'b0, 0, 0, 3, 32'h40, dc, d, io);
    chk("t5_idle_a4", log_a[4], 32'h0);
    chk("t5_new_a5", log_a[5], 32'h40);
    chk("t5_done_cyc", dc, 10);
    chk("t5_data", d, ref_word(32'h40, 4));

    // reset mid-store
    wlog.delete();
    seen = 1'b0;
    @(negedge clk_in);
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_size_i  = 2'd3;
    bus.ls_addr_i  = 32'h300;
    bus.ls_wdata_i = 32'h11223344;
    repeat (3) begin
      @(negedge clk_in);
      if (bus.ls_done_o) seen = 1'b1;
    end
    rst_n        = 1'b0;
    bus.ls_req_i = 1'b0;
    #1;
    chk("t6_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("t6_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("t6_mem_a", bus.mem_a, 32'h0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk_in);
      if (bus.ls_done_o) seen = 1'b1;
    end
    chk("t6_no_done", {31'd0, seen}, 32'd0);
    chk("t6_wcount", wlog.size(), 2);
    for (int k = 0; k < wlog.size() && k < 2; k++)
      chk("t6_wlog", wlog[k], {32'h300 + k, (k == 0) ? 8'h44 : 8'h33});
    ref_mem[32'h300] = 8'h44;
    ref_mem[32'h301] = 8'h33;

    // I/O boundary, wrap-around, random pauses: each I/O byte read exactly once
    do_acc(1'b1, 1'b0, 2'd3, 32'h2FFFE, 32'h0, 1'b1, 0, 0, -1, 32'h0, dc, d, io);
    chk("io_ld_data", d, ref_word(32'h2FFFE, 4));
    chk("io_ld_reads", io, 2);
    do_acc(1'b0, 1'b0, 2'd3, 32'h30000, 32'h0, 1'b1, 0, 0, -1, 32'h0, dc, d, io);
    chk("io_if_data", d, ref_word(32'h30000, 4));
    chk("io_if_reads", io, 4);
    do_acc(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 1'b0, 0, 0, -1, 32'h0, dc, d, io);
    chk("wrap_data", d, ref_word(32'hFFFFFFFE, 4));

    // randomized accesses against the byte model
    for (int it = 0; it < 40; it++) begin
      is_ls = $urandom_range(0, 1);
      we    = is_ls && $urandom_range(0, 1);
      sz    = is_ls ? 2'($urandom_range(0, 3)) : 2'd3;
      wd    = $urandom;
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom_range(0, 255);
        2: a = 32'h2FFFC + $urandom_range(0, 7);
        default: a = 32'hFFFFFFFC + $urandom_range(0, 3);
      endcase
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      wlog.delete();
      do_acc(is_ls, we, sz, a, wd, 1'b1, 0, 0, -1, 32'h0, dc, d, io);
      if (we) begin
        chk("rnd_wcount", wlog.size(), n);
        for (int k = 0; k < wlog.size() && k < n; k++)
          chk("rnd_wlog", wlog[k], {a + k, wd[8*k +: 8]});
        for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
      end else begin
        chk("rnd_rdata", d, ref_word(a, n));
        chk("rnd_io_reads", io, io_bytes(a, n));
        chk("rnd_no_wr", wlog.size(), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
